// File: rtl/fir_inverse_decoder_pkg.sv
// ============================================================================
//  Module   : fir_inverse_decoder_pkg
//  Brief    : Shared widths and FSM state type for the FIR inverse decoder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_inverse_decoder_pkg;

    // Widths shared with the 2-tap FIR filter
    localparam int DEF_DW = 8;
    localparam int DEF_PW = 2 * DEF_DW;

    typedef enum logic [2:0] {
        S_LOAD_H0 = 3'd0,
        S_LOAD_H1 = 3'd1,
        S_IDLE    = 3'd2,
        S_SUB     = 3'd3,
        S_DIV     = 3'd4,
        S_OUT     = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fir_inverse_decoder_divider.sv
// ============================================================================
//  Module   : fir_seq_divider
//  Brief    : Unsigned restoring divider, PW-bit dividend by DW-bit divisor,
//             one quotient bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_seq_divider
    import fir_inverse_decoder_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [PW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] quotient
);

    localparam int CW = $clog2(PW + 1);

    logic [DW-1:0] r_rem;
    logic [PW-1:0] r_quot;
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_cnt;

    logic [DW:0]   w_shift;
    logic          w_ge;
    logic [DW-1:0] w_sub;

    // Remainder always stays below the divisor, so DW bits hold it
    assign w_shift  = {r_rem, r_quot[PW-1]};
    assign w_ge     = (w_shift >= {1'b0, r_div});
    assign w_sub    = w_shift[DW-1:0] - r_div;

    assign busy     = (r_cnt != '0);
    // High during the final step, so the quotient is complete on the next cycle
    assign done     = (r_cnt == CW'(1));
    assign quotient = r_quot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
        end else if (start) begin
            r_rem  <= '0;
            r_quot <= dividend;
            r_div  <= divisor;
            r_cnt  <= CW'(PW);
        end else if (busy) begin
            r_rem  <= w_ge ? w_sub : w_shift[DW-1:0];
            r_quot <= {r_quot[PW-2:0], w_ge};
            r_cnt  <= r_cnt - CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_inverse_decoder.sv
// ============================================================================
//  Module   : fir_inverse_decoder
//  Brief    : Recovers x[n] = (p[n] - h1*x[n-1]) / h0 from 2-tap FIR products.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_inverse_decoder
    import fir_inverse_decoder_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] coef_in,
    input  logic          coef_valid,
    output logic          coef_done,
    input  logic [PW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_err
);

    state_t        r_state;
    state_t        w_next_state;
    logic [DW-1:0] r_h0;
    logic [DW-1:0] r_h1;
    logic [DW-1:0] r_x_prev;
    logic [PW-1:0] r_p;
    logic          r_err_u;

    logic [PW-1:0] w_t;
    logic          w_under;
    logic [PW-1:0] w_resid;
    logic          w_h0_zero;
    logic          w_accept;
    logic          w_div_start;
    logic          w_div_busy;
    logic          w_div_done;
    logic [PW-1:0] w_quot;
    logic [DW-1:0] w_q;
    logic          w_err;

    assign w_t       = PW'(r_h1) * PW'(r_x_prev);
    assign w_under   = (r_p < w_t);
    assign w_resid   = w_under ? '0 : (r_p - w_t);
    assign w_h0_zero = (r_h0 == '0);
    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_div_start = (r_state == S_SUB) && !w_h0_zero;

    fir_seq_divider #(
        .DW (DW),
        .PW (PW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .dividend (w_resid),
        .divisor  (r_h0),
        .busy     (w_div_busy),
        .done     (w_div_done),
        .quotient (w_quot)
    );

    // Result selection in priority order: h0 zero, overflow, underflow, normal
    always_comb begin
        w_q   = w_quot[DW-1:0];
        w_err = 1'b0;
        if (w_h0_zero) begin
            w_q   = '1;
            w_err = 1'b1;
        end else if (w_quot[PW-1:DW] != '0) begin
            w_q   = '1;
            w_err = 1'b1;
        end else if (r_err_u) begin
            w_q   = '0;
            w_err = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_LOAD_H0: if (coef_valid) w_next_state = S_LOAD_H1;
            S_LOAD_H1: if (coef_valid) w_next_state = S_IDLE;
            S_IDLE:    if (in_valid)   w_next_state = S_SUB;
            S_SUB:     w_next_state = w_h0_zero ? S_OUT : S_DIV;
            S_DIV:     if (w_div_done || !w_div_busy) w_next_state = S_OUT;
            S_OUT:     if (out_ready)  w_next_state = S_IDLE;
            default:   w_next_state = S_LOAD_H0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_LOAD_H0;
            r_h0     <= '0;
            r_h1     <= '0;
            r_x_prev <= '0;
            r_p      <= '0;
            r_err_u  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_LOAD_H0 && coef_valid) r_h0 <= coef_in;
            if (r_state == S_LOAD_H1 && coef_valid) r_h1 <= coef_in;
            if (w_accept)                           r_p  <= in_data;
            if (r_state == S_SUB)                   r_err_u <= w_under;
            // History feeds back the saturated value actually delivered
            if (r_state == S_OUT && out_ready)      r_x_prev <= w_q;
        end
    end

    assign coef_done = (r_state != S_LOAD_H0) && (r_state != S_LOAD_H1);
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_data  = (r_state == S_OUT) ? w_q : '0;
    assign out_err   = (r_state == S_OUT) ? w_err : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_fir_inverse_decoder.sv
// ============================================================================
//  Module   : tb_fir_inverse_decoder
//  Brief    : Self-checking bench for fir_inverse_decoder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_inverse_decoder;

    localparam int DW = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] coef_in = '0;
    logic          coef_valid = 1'b0;
    logic          coef_done;
    logic [PW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_err;

    fir_inverse_decoder #(.DW(DW), .PW(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .coef_done  (coef_done),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int m_h0, m_h1, m_x;

    typedef struct {
        int   p;
        int   q;
        logic err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        coef_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step;
        step;
        rst_n = 1'b1;
        m_h0 = 0; m_h1 = 0; m_x = 0;
    endtask

    task automatic load(input int a, input int b);
        coef_valid = 1'b1;
        coef_in = 8'(a);
        step;
        coef_in = 8'(b);
        step;
        coef_valid = 1'b0;
        m_h0 = a; m_h1 = b;
    endtask

    // Arithmetic reference: x = (p - h1*x_prev) / h0 with the saturation rules
    function automatic void model(input int p, output int q, output logic err);
        int t;
        int d;
        t = m_h1 * m_x;
        if (m_h0 == 0) begin
            q = 255; err = 1'b1;
        end else if (p < t) begin
            q = 0; err = 1'b1;
        end else begin
            d = (p - t) / m_h0;
            if (d > 255) begin
                q = 255; err = 1'b1;
            end else begin
                q = d; err = 1'b0;
            end
        end
    endfunction

    task automatic apply(input string name, input int p, input int eq, input logic eerr,
                         input int stall);
        int n;
        int elat;
        elat = (m_h0 == 0) ? 2 : PW + 2;
        n = 0;
        while (!in_ready && n < 100) begin
            step;
            n++;
        end
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data = 16'(p);
        out_ready = (stall == 0);
        step;
        in_valid = 1'b0;
        in_data = 16'($urandom);
        n = 1;
        while (!out_valid && n < 100) begin
            step;
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'(elat));
        chk({name, " data"}, 32'(out_data), 32'(eq));
        chk({name, " err"}, 32'(out_err), 32'(eerr));
        if (stall > 0) begin
            // Offer a competing sample while stalled; it must not be taken
            in_valid = 1'b1;
            in_data = 16'($urandom);
            for (int i = 0; i < stall; i++) begin
                step;
                chk({name, " hold"}, {22'd0, out_valid, in_ready, out_err, out_data},
                    {22'd0, 1'b1, 1'b0, eerr, 8'(eq)});
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        step;
        chk({name, " drop"}, 32'(out_valid), 32'd0);
        m_x = eq;
    endtask

    task automatic apply_rand(input string name, input int p, input int stall);
        int   q;
        logic e;
        model(p, q, e);
        apply(name, p, q, e, stall);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{p: 15, q: 5, err: 1'b0};
        tbl[1] = '{p: 31, q: 7, err: 1'b0};
        tbl[2] = '{p: 4,  q: 0, err: 1'b1};
        tbl[3] = '{p: 6,  q: 2, err: 1'b0};
        tbl[4] = '{p: 20, q: 5, err: 1'b0};

        do_reset;
        chk("reset outputs", {27'd0, coef_done, in_ready, out_valid, out_err, 1'b0},
            32'd0);
        chk("reset data", 32'(out_data), 32'd0);

        // h0=3, h1=2 table, including an underflow
        load(3, 2);
        chk("coef_done", {30'd0, coef_done, in_ready}, 32'd3);
        coef_valid = 1'b1;
        coef_in = 8'd0;
        step;
        step;
        coef_valid = 1'b0;
        for (int i = 0; i < 5; i++)
            apply($sformatf("tbl%0d", i), tbl[i].p, tbl[i].q, tbl[i].err, 0);

        // h0 = 0 short path
        do_reset;
        load(0, 1);
        apply("h0zero", 100, 255, 1'b1, 0);
        apply("h0zero2", 7, 255, 1'b1, 0);

        // Overflow saturation, then exact 255 without error
        do_reset;
        load(1, 0);
        apply("sat300", 300, 255, 1'b1, 0);
        apply("exact255", 255, 255, 1'b0, 0);

        // Long output stall
        do_reset;
        load(3, 2);
        apply("stall10", 15, 5, 1'b0, 10);
        apply("after_stall", 31, 7, 1'b0, 0);

        // Reset during division
        do_reset;
        load(3, 2);
        in_valid = 1'b1;
        in_data = 16'd100;
        step;
        in_valid = 1'b0;
        repeat (6) step;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst outputs", {23'd0, coef_done, in_ready, out_valid, out_err, out_data},
            32'd0);
        step;
        rst_n = 1'b1;
        m_h0 = 0; m_h1 = 0; m_x = 0;
        load(2, 0);
        apply("reload", 9, 4, 1'b0, 0);

        // Randomised coefficient sets against the arithmetic model
        for (int s = 0; s < 4; s++) begin
            int a;
            int b;
            do_reset;
            a = (s == 1) ? 0 : (s == 2) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 255));
            b = int'($urandom_range(0, 255));
            load(a, b);
            for (int k = 0; k < 12; k++) begin
                int p;
                int st;
                p = (k % 3 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 65535));
                st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
                apply_rand($sformatf("rnd%0d_%0d", s, k), p, st);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
